fp_add_issue: RTL

FP_ADD_ISSUE -- requirements
Module: fp_add_issue

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fp_classify.sv | 49 ++++
 rtl/fp_add_issue.sv | 88 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the adder issue path.
// Field widths, special constants, operand classes and a classifier.
package fpu_pkg;

   localparam int FP_W  = 32;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;
   localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
   localparam logic [FP_W-1:0]  QNAN     = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      CLS_NORMAL = 2'd0,
      CLS_ZERO   = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_class_t;

   // Denormals fall into CLS_ZERO: they are flushed downstream.
   function automatic fp_class_t fp_class(input logic [FP_W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = x[FP_W-2 -: EXP_W];
      m = x[MAN_W-1:0];
      if (e == EXP_ONES) return (m != '0) ? CLS_NAN : CLS_INF;
      if (e == EXP_ZERO) return CLS_ZERO;
      return CLS_NORMAL;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand sanitizer and special-case resolver.
// Ports: a, b (raw FP32) -> san_a, san_b, special, result.
module fp_classify
   import fpu_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] san_a,
   output logic [FP_W-1:0] san_b,
   output logic            special,
   output logic [FP_W-1:0] result
);

   fp_class_t ca;
   fp_class_t cb;

   assign ca = fp_class(a);
   assign cb = fp_class(b);

   // Zeros and denormals collapse to signed zero.
   assign san_a = (ca == CLS_ZERO) ? {a[FP_W-1], {(FP_W-1){1'b0}}} : a;
   assign san_b = (cb == CLS_ZERO) ? {b[FP_W-1], {(FP_W-1){1'b0}}} : b;

   // Priority chain; the fall-through case leaves two normals.
   always_comb begin
      special = 1'b1;
      result  = '0;
      if (ca == CLS_NAN || cb == CLS_NAN) begin
         result = QNAN;
      end else if (ca == CLS_INF && cb == CLS_INF
                   && a[FP_W-1] != b[FP_W-1]) begin
         result = QNAN;
      end else if (ca == CLS_INF) begin
         result = a;
      end else if (cb == CLS_INF) begin
         result = b;
      end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
         result = {a[FP_W-1] & b[FP_W-1], {(FP_W-1){1'b0}}};
      end else if (ca == CLS_ZERO) begin
         result = b;
      end else if (cb == CLS_ZERO) begin
         result = a;
      end else begin
         special = 1'b0;
         result  = '0;
      end
   end

endmodule

// File: rtl/fp_add_issue.sv
// Operand-pair FIFO feeding a combinational FP32 adder.
// Ports: in_valid/in_ready/in_a/in_b push side; out_* pop side; count.
module fp_add_issue
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FP_W-1:0]          in_a,
   input  logic [FP_W-1:0]          in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FP_W-1:0]          out_a,
   output logic [FP_W-1:0]          out_b,
   output logic                     out_special,
   output logic [FP_W-1:0]          out_special_result,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [FP_W-1:0] a_mem [DEPTH];
   logic [FP_W-1:0] b_mem [DEPTH];
   logic [FP_W-1:0] r_mem [DEPTH];
   logic            s_mem [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            push;
   logic            pop;

   logic [FP_W-1:0] san_a;
   logic [FP_W-1:0] san_b;
   logic            special;
   logic [FP_W-1:0] result;

   fp_classify u_cls (
      .a       (in_a),
      .b       (in_b),
      .san_a   (san_a),
      .san_b   (san_b),
      .special (special),
      .result  (result)
   );

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage is not reset; count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         a_mem[wr_ptr] <= san_a;
         b_mem[wr_ptr] <= san_b;
         r_mem[wr_ptr] <= result;
         s_mem[wr_ptr] <= special;
      end
   end

   // Power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign out_a              = out_valid ? a_mem[rd_ptr] : '0;
   assign out_b              = out_valid ? b_mem[rd_ptr] : '0;
   assign out_special        = out_valid ? s_mem[rd_ptr] : 1'b0;
   assign out_special_result = out_valid ? r_mem[rd_ptr] : '0;

endmodule
